// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, write-back, issue handshake and busy count.
// The master side drives addresses, strobes and data; the slave side is the register file.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_ok;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, iss_ok, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, iss_ok, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-entry pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

    logic              wr_hit;
    logic              iss_zero;
    logic              iss_ok;
    logic              iss_set;

    logic [NUM_RD*DATA_W-1:0] rd_data_v;
    logic [NUM_RD-1:0]        rd_busy_v;
    logic [ADDR_W-1:0]        ra;

    // Entry 0 is inert when hardwired to zero: never written, never marked busy.
    assign wr_hit   = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
    assign iss_zero = ZERO_REG && (bus.iss_addr == '0);
    assign iss_ok   = iss_zero || !busy_q[bus.iss_addr] ||
                      (bus.wr_en && (bus.wr_addr == bus.iss_addr));
    assign iss_set  = bus.iss_en && iss_ok && !iss_zero;

    // Set is applied after clear so a new producer keeps ownership on a same-cycle collision.
    always_comb begin
        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[bus.wr_addr] = 1'b0;
        end
        if (iss_set) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_hit) begin
                mem_q[bus.wr_addr] <= bus.wr_data;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        rd_data_v = '0;
        rd_busy_v = '0;
        ra        = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            rd_data_v[k*DATA_W +: DATA_W] = mem_q[ra];
            rd_busy_v[k]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (bus.wr_addr == ra)) begin
                rd_data_v[k*DATA_W +: DATA_W] = bus.wr_data;
                rd_busy_v[k]                  = 1'b0;
            end
`endif
            if (ZERO_REG && (ra == '0)) begin
                rd_data_v[k*DATA_W +: DATA_W] = '0;
                rd_busy_v[k]                  = 1'b0;
            end
        end
    end

    assign bus.rd_data  = rd_data_v;
    assign bus.rd_busy  = rd_busy_v;
    assign bus.iss_ok   = iss_ok;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default instance and a ZERO_REG=1 instance.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic rst_nz;
    int   n_checks;
    int   n_errors;

    regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) m_if ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) z_if ();

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1'b1)) u_dut_z (
        .clk   (clk),
        .rst_n (rst_nz),
        .bus   (z_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
        m_if.rd_addr = {a1, a0};
    endtask

    task automatic set_rdz(input logic [2:0] a0, input logic [2:0] a1);
        z_if.rd_addr = {a1, a0};
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        rst_nz = 1'b0;
        m_if.rd_addr = '0; m_if.wr_en = 1'b0; m_if.wr_addr = '0; m_if.wr_data = '0;
        m_if.iss_en = 1'b0; m_if.iss_addr = '0;
        z_if.rd_addr = '0; z_if.wr_en = 1'b0; z_if.wr_addr = '0; z_if.wr_data = '0;
        z_if.iss_en = 1'b0; z_if.iss_addr = '0;
        step(); step();
        rst_n = 1'b1;

        // Post-reset state
        set_rd(3'd0, 3'd7); #1;
        check("rst0_rd0", m_if.rd_data[15:0], 32'h0);
        check("rst0_rd1", m_if.rd_data[31:16], 32'h0);
        check("rst0_busy", m_if.rd_busy, 32'h0);
        check("rst0_cnt", m_if.busy_cnt, 32'h0);
        check("rst0_issok", m_if.iss_ok, 32'h1);

        // Preload 0xA5A5 everywhere, then reset
        for (int i = 0; i < 8; i++) begin
            m_if.wr_en = 1'b1; m_if.wr_addr = 3'(i); m_if.wr_data = 16'hA5A5;
            step();
        end
        m_if.wr_en = 1'b0;
        set_rd(3'd7, 3'd0); #1;
        check("pre_r7", m_if.rd_data[15:0], 32'hA5A5);
        check("pre_r0", m_if.rd_data[31:16], 32'hA5A5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_rd(3'(i), 3'(7 - i)); #1;
            check("rst_data0", m_if.rd_data[15:0], 32'h0);
            check("rst_data1", m_if.rd_data[31:16], 32'h0);
        end
        check("rst_cnt", m_if.busy_cnt, 32'h0);

        // Scoreboard on r3
        set_rd(3'd3, 3'd0);
        m_if.iss_en = 1'b1; m_if.iss_addr = 3'd3; #1;
        check("iss3_ok", m_if.iss_ok, 32'h1);
        step();
        check("iss3_busy", m_if.rd_busy[0], 32'h1);
        check("iss3_cnt", m_if.busy_cnt, 32'h1);
        check("iss3_again_ok", m_if.iss_ok, 32'h0);
        step();
        check("iss3_stall_cnt", m_if.busy_cnt, 32'h1);
        check("iss3_stall_busy", m_if.rd_busy[0], 32'h1);
        m_if.iss_en = 1'b0;
        m_if.wr_en = 1'b1; m_if.wr_addr = 3'd3; m_if.wr_data = 16'h1234; #1;
        check("wr3_same_data", m_if.rd_data[15:0], Byp ? 32'h1234 : 32'h0);
        check("wr3_same_busy", m_if.rd_busy[0], Byp ? 32'h0 : 32'h1);
        step();
        m_if.wr_en = 1'b0; #1;
        check("wr3_busy", m_if.rd_busy[0], 32'h0);
        check("wr3_cnt", m_if.busy_cnt, 32'h0);
        check("wr3_data", m_if.rd_data[15:0], 32'h1234);

        // Same-cycle write+issue r5, first while not busy
        set_rd(3'd0, 3'd5);
        m_if.wr_en = 1'b1; m_if.wr_addr = 3'd5; m_if.wr_data = 16'h00FF;
        m_if.iss_en = 1'b1; m_if.iss_addr = 3'd5; #1;
        check("wi5_ok", m_if.iss_ok, 32'h1);
        step();
        m_if.wr_en = 1'b0; m_if.iss_en = 1'b0; #1;
        check("wi5_data", m_if.rd_data[31:16], 32'h00FF);
        check("wi5_busy", m_if.rd_busy[1], 32'h1);
        check("wi5_cnt", m_if.busy_cnt, 32'h1);
        // Again while busy: issue accepted through the write
        set_rd(3'd5, 3'd5);
        m_if.iss_en = 1'b1; m_if.iss_addr = 3'd5; #1;
        check("wi5b_blocked", m_if.iss_ok, 32'h0);
        m_if.wr_en = 1'b1; m_if.wr_addr = 3'd5; m_if.wr_data = 16'h0A0A; #1;
        check("wi5b_ok", m_if.iss_ok, 32'h1);
        check("wi5b_same_busy", m_if.rd_busy[0], Byp ? 32'h0 : 32'h1);
        step();
        m_if.wr_en = 1'b0; m_if.iss_en = 1'b0; #1;
        check("wi5b_data", m_if.rd_data[15:0], 32'h0A0A);
        check("wi5b_busy", m_if.rd_busy[0], 32'h1);
        check("wi5b_cnt", m_if.busy_cnt, 32'h1);

        // Bypass on r2
        set_rd(3'd2, 3'd3);
        m_if.wr_en = 1'b1; m_if.wr_addr = 3'd2; m_if.wr_data = 16'hBEEF; #1;
        check("byp_same", m_if.rd_data[15:0], Byp ? 32'hBEEF : 32'h0);
        check("byp_other", m_if.rd_data[31:16], 32'h1234);
        step();
        m_if.wr_en = 1'b0; #1;
        check("byp_next", m_if.rd_data[15:0], 32'hBEEF);

        // Release r5, then fill every entry
        m_if.wr_en = 1'b1; m_if.wr_addr = 3'd5; m_if.wr_data = 16'h0055;
        step();
        m_if.wr_en = 1'b0; #1;
        check("clr5_cnt", m_if.busy_cnt, 32'h0);
        for (int i = 0; i < 8; i++) begin
            m_if.iss_en = 1'b1; m_if.iss_addr = 3'(i);
            step();
        end
        m_if.iss_en = 1'b0; #1;
        check("fill_cnt", m_if.busy_cnt, 32'h8);
        for (int i = 0; i < 8; i++) begin
            m_if.iss_addr = 3'(i); #1;
            check("fill_issok", m_if.iss_ok, 32'h0);
        end
        m_if.iss_en = 1'b1; m_if.iss_addr = 3'd4;
        step();
        m_if.iss_en = 1'b0; #1;
        check("fill_stall_cnt", m_if.busy_cnt, 32'h8);

        // Retire r0..r3, then reset mid-operation with write+issue pending
        for (int i = 0; i < 4; i++) begin
            m_if.wr_en = 1'b1; m_if.wr_addr = 3'(i); m_if.wr_data = 16'(16'h10 + i);
            step();
        end
        m_if.wr_en = 1'b0;
        set_rd(3'd2, 3'd6); #1;
        check("mid_cnt", m_if.busy_cnt, 32'h4);
        check("mid_r2", m_if.rd_data[15:0], 32'h12);
        check("mid_busy", m_if.rd_busy, 32'h2);
        rst_n = 1'b0;
        m_if.wr_en = 1'b1; m_if.wr_addr = 3'd1; m_if.wr_data = 16'h7777;
        m_if.iss_en = 1'b1; m_if.iss_addr = 3'd1;
        step();
        rst_n = 1'b1; m_if.wr_en = 1'b0; m_if.iss_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_rd(3'(i), 3'(i)); #1;
            check("mrst_data", m_if.rd_data[15:0], 32'h0);
            check("mrst_busy", m_if.rd_busy, 32'h0);
        end
        check("mrst_cnt", m_if.busy_cnt, 32'h0);

        // ZERO_REG=1 instance
        rst_nz = 1'b1;
        set_rdz(3'd0, 3'd1);
        z_if.iss_addr = 3'd0; #1;
        check("z_issok0", z_if.iss_ok, 32'h1);
        z_if.wr_en = 1'b1; z_if.wr_addr = 3'd0; z_if.wr_data = 16'hFFFF; #1;
        check("z_wr0_same", z_if.rd_data[15:0], 32'h0);
        step();
        z_if.wr_en = 1'b0; #1;
        check("z_wr0_data", z_if.rd_data[15:0], 32'h0);
        z_if.iss_en = 1'b1; z_if.iss_addr = 3'd0;
        step();
        z_if.iss_en = 1'b0; #1;
        check("z_iss0_cnt", z_if.busy_cnt, 32'h0);
        check("z_iss0_busy", z_if.rd_busy[0], 32'h0);
        for (int i = 0; i < 8; i++) begin
            z_if.iss_en = 1'b1; z_if.iss_addr = 3'(i);
            step();
        end
        z_if.iss_en = 1'b0; #1;
        check("z_fill_cnt", z_if.busy_cnt, 32'h7);
        check("z_fill_busy", z_if.rd_busy, 32'h2);
        z_if.iss_addr = 3'd0; #1;
        check("z_fill_issok0", z_if.iss_ok, 32'h1);
        z_if.iss_addr = 3'd6; #1;
        check("z_fill_issok6", z_if.iss_ok, 32'h0);
        z_if.wr_en = 1'b1; z_if.wr_addr = 3'd1; z_if.wr_data = 16'h1111;
        step();
        z_if.wr_en = 1'b0; #1;
        check("z_wr1_data", z_if.rd_data[31:16], 32'h1111);
        check("z_wr1_cnt", z_if.busy_cnt, 32'h6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
